// File: rtl/ula_seq.sv
// ula_seq: multi-cycle ALU with valid/ready handshakes on both sides.
//   Single-cycle ops load their result on the accept edge (latency 1).
//   MUL (000100) uses a shift-add unit and DIV (000101) a restoring divider.
//   Each handles one bit per cycle, so the result is ready WIDTH+1 cycles after accept.
//   Divide by zero completes in one cycle with result all ones and div_zero set.
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    request handshake (alu_op, dado_1, dado_2)
//   out_valid/out_ready  result handshake (result, saida, branch, div_zero)
//   busy                 multi-cycle operation in progress
// Optional: define ULA_FLAGS_EN to add flags = {negative, zero, carry, overflow}.
module ula_seq #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alu_op,
  input  logic [WIDTH-1:0] dado_1,
  input  logic [WIDTH-1:0] dado_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] saida,
  output logic             branch,
  output logic             div_zero,
  output logic             busy
`ifdef ULA_FLAGS_EN
  ,
  output logic [3:0]       flags
`endif
);

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_MUL = 6'b000100;
  localparam logic [5:0] OP_DIV = 6'b000101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state;
  logic [SHW:0]     count;
  logic [WIDTH-1:0] work_a;   // MUL: shifted multiplicand; DIV: dividend becoming quotient
  logic [WIDTH-1:0] work_b;   // MUL: shifted multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc;      // MUL: partial product;      DIV: partial remainder
  logic [WIDTH-1:0] hold_a;   // dado_1 kept for saida of a long op

  logic accept;
  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Single-cycle decode, used directly on the accept edge.
  logic [WIDTH-1:0] comb_result, comb_saida;
  logic             comb_branch;
  logic             shift_big;
  assign shift_big = |dado_2[WIDTH-1:SHW];

  always_comb begin
    comb_result = dado_1;
    comb_saida  = dado_1;
    comb_branch = 1'b0;
    case (alu_op)
      6'b000000:            comb_result = dado_1 + dado_2;
      6'b000001, 6'b100010: comb_result = dado_2;
      6'b000010, 6'b000011: comb_result = dado_1 - dado_2;
      6'b000101:            comb_result = '1;  // only reaches here as divide by zero
      6'b001000, 6'b001001: comb_result = dado_1 & dado_2;
      6'b001010, 6'b001011: comb_result = dado_1 | dado_2;
      6'b001100:            comb_result = ~dado_1;
      6'b001101:            comb_result = dado_1 ^ dado_2;
      6'b010000: comb_result = shift_big ? '0 : (dado_1 << dado_2[SHW-1:0]);
      6'b010001: comb_result = shift_big ? '0 : (dado_1 >> dado_2[SHW-1:0]);
      6'b100000, 6'b100001, 6'b111100, 6'b111101, 6'b111110: comb_saida = dado_2;
      6'b111111: begin
        comb_saida  = dado_2;
        comb_branch = 1'b1;
      end
      6'b011000:            comb_branch = (dado_1 == dado_2);
      6'b011001:            comb_branch = (dado_1 != dado_2);
      6'b011010:            comb_branch = (dado_1 > dado_2);
      6'b011011:            comb_branch = (dado_1 < dado_2);
      6'b011100, 6'b011101: comb_branch = 1'b1;
      default: ;
    endcase
  end

`ifdef ULA_FLAGS_EN
  logic [WIDTH:0] add_full, sub_full;
  logic           comb_carry, comb_ovf;
  assign add_full = {1'b0, dado_1} + {1'b0, dado_2};
  assign sub_full = {1'b0, dado_1} - {1'b0, dado_2};

  always_comb begin
    comb_carry = 1'b0;
    comb_ovf   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        comb_carry = add_full[WIDTH];
        comb_ovf   = (dado_1[WIDTH-1] == dado_2[WIDTH-1]) &&
                     (add_full[WIDTH-1] != dado_1[WIDTH-1]);
      end
      6'b000010, 6'b000011: begin
        comb_carry = sub_full[WIDTH];  // borrow
        comb_ovf   = (dado_1[WIDTH-1] != dado_2[WIDTH-1]) &&
                     (sub_full[WIDTH-1] != dado_1[WIDTH-1]);
      end
      default: ;
    endcase
  end

  function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction
`endif

  // One shift-add step: the low WIDTH bits of the product are all that is kept.
  logic [WIDTH-1:0] mul_acc_next;
  assign mul_acc_next = work_b[0] ? (acc + work_a) : acc;

  // One restoring-division step.
  // The remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next, div_quo_next;
  assign div_shift    = {acc, work_a[WIDTH-1]};
  assign div_ge       = (div_shift >= {1'b0, work_b});
  assign div_rem_next = div_ge ? (div_shift[WIDTH-1:0] - work_b) : div_shift[WIDTH-1:0];
  assign div_quo_next = {work_a[WIDTH-2:0], div_ge};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      count     <= '0;
      work_a    <= '0;
      work_b    <= '0;
      acc       <= '0;
      hold_a    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      saida     <= '0;
      branch    <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
`ifdef ULA_FLAGS_EN
      flags     <= 4'b0;
`endif
    end else begin
      // A consumed result drops; a load below on the same edge overrides this.
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (alu_op == OP_MUL || (alu_op == OP_DIV && dado_2 != '0)) begin
              state  <= (alu_op == OP_MUL) ? S_MUL : S_DIV;
              busy   <= 1'b1;
              count  <= (SHW+1)'(WIDTH);
              work_a <= dado_1;
              work_b <= dado_2;
              acc    <= '0;
              hold_a <= dado_1;
            end else begin
              out_valid <= 1'b1;
              result    <= comb_result;
              saida     <= comb_saida;
              branch    <= comb_branch;
              div_zero  <= (alu_op == OP_DIV);
`ifdef ULA_FLAGS_EN
              flags     <= flags_of(comb_result, comb_carry, comb_ovf);
`endif
            end
          end
        end
        S_MUL, S_DIV: begin
          count <= count - 1'b1;
          if (state == S_MUL) begin
            acc    <= mul_acc_next;
            work_a <= work_a << 1;
            work_b <= work_b >> 1;
          end else begin
            acc    <= div_rem_next;
            work_a <= div_quo_next;
          end
          // The last step finishes on the WIDTH-th edge after accept.
          if (count == (SHW+1)'(1)) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= (state == S_MUL) ? mul_acc_next : div_quo_next;
            saida     <= hold_a;
            branch    <= 1'b0;
            div_zero  <= 1'b0;
`ifdef ULA_FLAGS_EN
            flags     <= flags_of((state == S_MUL) ? mul_acc_next : div_quo_next, 1'b0, 1'b0);
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, multi-cycle successor to the processor's combinational ALU.
- Keeps the existing 6-bit alu_op encoding and the result/saida/branch semantics.
- Generalises the datapath width and replaces the combinational multiply and divide with iterative one-bit-per-cycle units.
- Adds valid/ready handshakes on both sides, so the control unit can stall on long operations.

Parameters:
- WIDTH, 32, datapath width in bits; minimum 4, power of two.
- SHW, $clog2(WIDTH), number of shift-amount bits; derived, do not override.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- alu_op  input  6  opcode, same encoding as the current ALU.
- dado_1  input  WIDTH  operand 1.
- dado_2  input  WIDTH  operand 2 / immediate.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  ALU result.
- saida  output  WIDTH  pass-through operand (store data / port data).
- branch  output  1  branch-taken.
- div_zero  output  1  result came from a division by zero.
- busy  output  1  multi-cycle operation in progress.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - out_valid, branch, div_zero and busy are 0; result and saida are 0.
  - Any in-flight mul/div is discarded; a request held in the accept cycle is lost.
- Handshake:
  - A request is accepted on a rising edge with in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Outputs hold stable while out_valid && !out_ready.
  - out_valid falls on the edge after out_valid && out_ready, unless a new result loads on that same edge.
- States: IDLE, MUL, DIV.
  - IDLE: single-cycle op accepted -> outputs load on the accept edge; out_valid=1 next cycle (latency 1, throughput 1 per cycle).
  - Op 000100 (MUL) accepted -> go to MUL; busy=1; counter=WIDTH.
  - Op 000101 (DIV) accepted with dado_2!=0 -> go to DIV; busy=1; counter=WIDTH.
  - MUL: unsigned shift-add, one multiplier bit per cycle. After WIDTH cycles, load result = low WIDTH bits of the product and set out_valid. Return to IDLE; busy=0. out_valid asserts WIDTH+1 cycles after accept.
  - DIV: unsigned restoring division, one quotient bit per cycle. After WIDTH cycles, result = quotient (remainder discarded). Same latency as MUL.
  - DIV with dado_2==0: no DIV state. Result = all ones, div_zero=1, latency 1.
  - div_zero clears when the next result loads.
- Operand capture: operands and opcode are registered at accept; later input changes are ignored.
- Output per opcode (saida=dado_1 and branch=0 unless stated):
  - 000000: add, modulo 2^WIDTH.
  - 000001, 100010: result = dado_2.
  - 000010, 000011: subtract, modulo 2^WIDTH.
  - 001000, 001001: AND.
  - 001010, 001011: OR.
  - 001100: NOT dado_1.
  - 001101: XOR.
  - 010000: SLL; 010001: SRL. If dado_2 >= WIDTH, result = 0; otherwise shift by dado_2[SHW-1:0].
  - 100000, 100001, 111100, 111101, 111110: result = dado_1, saida = dado_2.
  - 111111: as the previous item, plus branch = 1.
  - 011000: result = dado_1; branch = (dado_1 == dado_2).
  - 011001: result = dado_1; branch = (dado_1 != dado_2).
  - 011010: result = dado_1; branch = (dado_1 > dado_2), unsigned.
  - 011011: result = dado_1; branch = (dado_1 < dado_2), unsigned.
  - 011100, 011101: result = dado_1; branch = 1.
  - Any other opcode: result = dado_1, saida = dado_1, branch = 0.
- Backpressure: out_valid=1 with out_ready=0 blocks new accepts. A finishing mul/div never overwrites an unconsumed result, because it could only be accepted when the output slot was free.

Optional Feature:
- Macro: ULA_FLAGS_EN.
- Defined: adds a 4-bit output port flags = {negative, zero, carry, overflow}, loaded with result.
  - zero = (result == 0).
  - negative = result[WIDTH-1].
  - carry = carry-out for add, borrow for sub.
  - overflow = two's-complement overflow for add/sub.
  - carry and overflow are 0 for all other ops.
  - flags is 0 at reset.
- Undefined: no flags port and no flag logic.

Test Plan:
- WIDTH=32, ADD 7+5 then SUB 3-5 back-to-back with out_ready=1 -> out_valid on consecutive cycles; results 12, then 0xFFFFFFFE.
- MUL 0x10000 * 0x10003 -> busy for 32 cycles; out_valid 33 cycles after accept; result 0x00030000; in_ready=0 throughout.
- DIV 100/7 -> result 14 after 33 cycles. DIV 9/0 -> result 0xFFFFFFFF, div_zero=1, latency 1.
- BEQ 5,5 -> branch=1. BLT 5,3 -> branch=0. Op 100000 with dado_1=0xA, dado_2=0xB -> result 0xA, saida 0xB. SLL 1<<40 -> result 0.
- Hold out_ready=0 for 5 cycles after an ADD -> outputs stable, in_ready=0; the next op is accepted on the edge where out_ready=1.
- Assert reset_n=0 mid-DIV (cycle 10) -> all outputs 0 immediately; after release, ADD 1+1 gives 2 with latency 1.
